// File: rtl/jtag_tap_sampled.sv
`default_nettype none
// ============================================================================
// Module   : jtag_tap_sampled
// Purpose  : Oversampled IEEE 1149.1 TAP responder. All JTAG pins are
//            synchronised into clk_in, TCK edges are detected as one-cycle
//            events, and the 16-state TAP FSM runs on those events.
//            Data registers: IDCODE (32), USER mailbox (32), BYPASS (1).
//            clk_in must run at least 4x TCK (6x with the glitch filter).
// Revision : 1.0 - initial release
//
// Ports:
//   clk_in           in   system clock, only clock of the block
//   reset            in   synchronous active-high reset
//   jtag_tck/tms/tdi in   JTAG pins, asynchronous to clk_in
//   jtag_trstn       in   JTAG TRST, active low
//   jtag_tdo         out  TDO data, changes on TCK falling events
//   jtag_tdo_oe      out  TDO enable, high only while shifting
//   user_dr_i        in   value captured into USER at Capture-DR
//   user_dr_o        out  USER contents latched at Update-DR
//   user_dr_valid_o  out  one-cycle pulse when user_dr_o is written
//   tap_state_o      out  current TAP state, IEEE encoding
//
// Optional feature:
//   JTAG_TAP_GLITCH_FILTER_EN - synced TCK must hold a new level for two
//   clk_in cycles before it is accepted; adds one cycle of latency.
// ============================================================================
module jtag_tap_sampled #(
  parameter int                  IR_WIDTH     = 5,
  parameter logic [31:0]         IDCODE_VAL   = 32'hFEED_0C53,
  parameter logic [IR_WIDTH-1:0] INSTR_IDCODE = 5'h01,
  parameter logic [IR_WIDTH-1:0] INSTR_USER   = 5'h10,
  parameter logic [IR_WIDTH-1:0] INSTR_BYPASS = 5'h1F,
  parameter int                  SYNC_STAGES  = 2
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        jtag_tck,
  input  logic        jtag_tms,
  input  logic        jtag_tdi,
  input  logic        jtag_trstn,
  output logic        jtag_tdo,
  output logic        jtag_tdo_oe,
  input  logic [31:0] user_dr_i,
  output logic [31:0] user_dr_o,
  output logic        user_dr_valid_o,
  output logic [3:0]  tap_state_o
);

  typedef enum logic [3:0] {
    TLR        = 4'hF,
    RTI        = 4'hC,
    SELECT_DR  = 4'h7,
    CAPTURE_DR = 4'h6,
    SHIFT_DR   = 4'h2,
    EXIT1_DR   = 4'h1,
    PAUSE_DR   = 4'h3,
    EXIT2_DR   = 4'h0,
    UPDATE_DR  = 4'h5,
    SELECT_IR  = 4'h4,
    CAPTURE_IR = 4'hE,
    SHIFT_IR   = 4'hA,
    EXIT1_IR   = 4'h9,
    PAUSE_IR   = 4'hB,
    EXIT2_IR   = 4'h8,
    UPDATE_IR  = 4'hD
  } tap_state_e;

  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = {{(IR_WIDTH-2){1'b0}}, 2'b01};

  // --------------------------------------------------------------------------
  // Input synchronisers. All four pins share the same depth so tms/tdi stay
  // aligned with the synced tck.
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] tck_sync_q, tms_sync_q, tdi_sync_q, trstn_sync_q;
  logic tck_s, tms_s, tdi_s, trstn_s;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      tck_sync_q   <= '0;
      tms_sync_q   <= '0;
      tdi_sync_q   <= '0;
      trstn_sync_q <= '1;  // deasserted, so reset release is not seen as a TRST
    end else begin
      tck_sync_q   <= {tck_sync_q[SYNC_STAGES-2:0], jtag_tck};
      tms_sync_q   <= {tms_sync_q[SYNC_STAGES-2:0], jtag_tms};
      tdi_sync_q   <= {tdi_sync_q[SYNC_STAGES-2:0], jtag_tdi};
      trstn_sync_q <= {trstn_sync_q[SYNC_STAGES-2:0], jtag_trstn};
    end
  end

  assign tck_s   = tck_sync_q[SYNC_STAGES-1];
  assign tms_s   = tms_sync_q[SYNC_STAGES-1];
  assign tdi_s   = tdi_sync_q[SYNC_STAGES-1];
  assign trstn_s = trstn_sync_q[SYNC_STAGES-1];

  // --------------------------------------------------------------------------
  // TCK edge detection (optionally glitch filtered)
  // --------------------------------------------------------------------------
  logic tck_cur, tck_prev, tck_rise, tck_fall;

`ifdef JTAG_TAP_GLITCH_FILTER_EN
  // A new level is accepted once it has been seen on two consecutive cycles;
  // the accepted level is registered and also serves as the edge reference.
  logic tck_hold_q, tck_filt_q;

  assign tck_cur  = (tck_s == tck_hold_q) ? tck_s : tck_filt_q;
  assign tck_prev = tck_filt_q;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      tck_hold_q <= 1'b0;
      tck_filt_q <= 1'b0;
    end else begin
      tck_hold_q <= tck_s;
      tck_filt_q <= tck_cur;
    end
  end
`else
  logic tck_prev_q;

  assign tck_cur  = tck_s;
  assign tck_prev = tck_prev_q;

  always_ff @(posedge clk_in) begin
    if (reset) tck_prev_q <= 1'b0;
    else       tck_prev_q <= tck_s;
  end
`endif

  assign tck_rise = ~tck_prev & tck_cur;
  assign tck_fall = tck_prev & ~tck_cur;

  // --------------------------------------------------------------------------
  // TAP state machine
  // --------------------------------------------------------------------------
  tap_state_e state_q, state_d;

  always_ff @(posedge clk_in) begin
    if (reset) state_q <= TLR;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!trstn_s) begin
      state_d = TLR;
    end else if (tck_rise) begin
      unique case (state_q)
        TLR:        state_d = tms_s ? TLR       : RTI;
        RTI:        state_d = tms_s ? SELECT_DR : RTI;
        SELECT_DR:  state_d = tms_s ? SELECT_IR : CAPTURE_DR;
        CAPTURE_DR: state_d = tms_s ? EXIT1_DR  : SHIFT_DR;
        SHIFT_DR:   state_d = tms_s ? EXIT1_DR  : SHIFT_DR;
        EXIT1_DR:   state_d = tms_s ? UPDATE_DR : PAUSE_DR;
        PAUSE_DR:   state_d = tms_s ? EXIT2_DR  : PAUSE_DR;
        EXIT2_DR:   state_d = tms_s ? UPDATE_DR : SHIFT_DR;
        UPDATE_DR:  state_d = tms_s ? SELECT_DR : RTI;
        SELECT_IR:  state_d = tms_s ? TLR       : CAPTURE_IR;
        CAPTURE_IR: state_d = tms_s ? EXIT1_IR  : SHIFT_IR;
        SHIFT_IR:   state_d = tms_s ? EXIT1_IR  : SHIFT_IR;
        EXIT1_IR:   state_d = tms_s ? UPDATE_IR : PAUSE_IR;
        PAUSE_IR:   state_d = tms_s ? EXIT2_IR  : PAUSE_IR;
        EXIT2_IR:   state_d = tms_s ? UPDATE_IR : SHIFT_IR;
        UPDATE_IR:  state_d = tms_s ? SELECT_DR : RTI;
        default:    state_d = TLR;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Instruction / data registers and TDO. Register actions belong to the
  // state the TAP is in when the rising event occurs.
  // --------------------------------------------------------------------------
  logic [IR_WIDTH-1:0] ir_q, ir_sr_q;
  logic [31:0]         dr_sr_q, user_dr_q;
  logic                byp_q, valid_q, tdo_q, tdo_oe_q;
  logic                sel_idcode, sel_user, sel_bypass, dr_lsb;

  assign sel_idcode = (ir_q == INSTR_IDCODE);
  assign sel_user   = (ir_q == INSTR_USER);
  assign sel_bypass = ~sel_idcode & ~sel_user;  // INSTR_BYPASS and all unlisted opcodes
  assign dr_lsb     = sel_bypass ? byp_q : dr_sr_q[0];

  always_ff @(posedge clk_in) begin
    if (reset) begin
      ir_q      <= INSTR_IDCODE;
      ir_sr_q   <= '0;
      dr_sr_q   <= '0;
      byp_q     <= 1'b0;
      user_dr_q <= '0;
      valid_q   <= 1'b0;
      tdo_q     <= 1'b0;
      tdo_oe_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (!trstn_s) begin
        ir_q     <= INSTR_IDCODE;
        tdo_oe_q <= 1'b0;
      end else if (tck_rise) begin
        unique case (state_q)
          CAPTURE_IR: ir_sr_q <= IR_CAPTURE;
          SHIFT_IR:   ir_sr_q <= {tdi_s, ir_sr_q[IR_WIDTH-1:1]};
          UPDATE_IR:  ir_q    <= ir_sr_q;
          CAPTURE_DR: begin
            if (sel_idcode)    dr_sr_q <= IDCODE_VAL;
            else if (sel_user) dr_sr_q <= user_dr_i;
            else               byp_q   <= 1'b0;
          end
          SHIFT_DR: begin
            if (sel_bypass) byp_q   <= tdi_s;
            else            dr_sr_q <= {tdi_s, dr_sr_q[31:1]};
          end
          UPDATE_DR: begin
            if (sel_user) begin
              user_dr_q <= dr_sr_q;
              valid_q   <= 1'b1;
            end
          end
          default: ;
        endcase
        if (state_d == TLR) ir_q <= INSTR_IDCODE;
      end else if (tck_fall) begin
        if (state_q == SHIFT_DR) begin
          tdo_q    <= dr_lsb;
          tdo_oe_q <= 1'b1;
        end else if (state_q == SHIFT_IR) begin
          tdo_q    <= ir_sr_q[0];
          tdo_oe_q <= 1'b1;
        end else begin
          tdo_oe_q <= 1'b0;  // tdo keeps its last value
        end
      end
    end
  end

  assign jtag_tdo        = tdo_q;
  assign jtag_tdo_oe     = tdo_oe_q;
  assign user_dr_o       = user_dr_q;
  assign user_dr_valid_o = valid_q;
  assign tap_state_o     = state_q;

endmodule
`default_nettype wire
